// File: rtl/note_scheduler_pkg.sv
// Shared definitions for the note scheduler: FSM encoding, LFSR geometry and lane width.
package note_scheduler_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDraw,
    StPush
  } state_e;

  localparam int unsigned LfsrWidth  = 13;
  localparam logic [LfsrWidth-1:0] LfsrSeed = 13'h1557;

  // Feedback taps of the left-shifting LFSR
  localparam int unsigned TapA = 12;
  localparam int unsigned TapB = 3;
  localparam int unsigned TapC = 2;
  localparam int unsigned TapD = 0;

  localparam int unsigned LaneWidth  = 4;
  localparam int unsigned DrawCycles = 13;

  // One LFSR step: shift left, feedback into bit 0
  function automatic logic [LfsrWidth-1:0] lfsr_next(logic [LfsrWidth-1:0] v);
    return {v[LfsrWidth-2:0], v[TapA] ^ v[TapB] ^ v[TapC] ^ v[TapD]};
  endfunction

endpackage

// File: rtl/note_scheduler_lfsr13_step.sv
// 13-bit note LFSR; advances one step per cycle while step is high.
module lfsr13_step
  import note_scheduler_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 step,
  output logic [LfsrWidth-1:0] value
);

  // Seeded on reset, otherwise steps on request; never reaches all-zero from the seed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= LfsrSeed;
    end else if (step) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/note_scheduler.sv
// Beat-driven note scheduler: draws a random lane mask each beat and queues it for a consumer.
module note_scheduler
  import note_scheduler_pkg::*;
#(
  parameter int unsigned BEAT_TICKS = 50,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 pause,
  input  logic                 stop,
  input  logic                 note_ready,
  output logic [LaneWidth-1:0] note_data,
  output logic                 note_valid,
  output logic                 busy,
  output logic                 overflow,
  output logic                 beat_miss
);

  localparam int unsigned CntW = $clog2(BEAT_TICKS);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [CntW-1:0] CntMax    = CntW'(BEAT_TICKS - 1);
  localparam logic [PtrW:0]   CountFull = (PtrW + 1)'(DEPTH);
  localparam logic [3:0]      DrawLast  = 4'(DrawCycles - 1);

  state_e              state_q;
  logic [CntW-1:0]     beat_cnt_q;
  logic [3:0]          draw_cnt_q;
  logic                pending_q;
  logic                beat_miss_q;

  logic [LaneWidth-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]        count_q;
  logic                 overflow_q;

  logic                 tick, push, push_ok, pop, full, lfsr_step;
  logic [LfsrWidth-1:0] lfsr_value;
  // Only the top lane bits form a note; the rest just feed the shift chain
  logic [LfsrWidth-LaneWidth-1:0] lfsr_unused;

  assign lfsr_unused = lfsr_value[LfsrWidth-LaneWidth-1:0];

  assign tick      = (state_q != StIdle) && !pause && (beat_cnt_q == CntMax);
  assign lfsr_step = (state_q == StDraw) && !pause && !stop;
  assign push      = (state_q == StPush) && !pause && !stop;
  assign pop       = note_valid && note_ready && !stop;
  assign full      = (count_q == CountFull);
  // A full queue still accepts the push when the head leaves in the same cycle
  assign push_ok   = push && (!full || pop);

  lfsr13_step u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (lfsr_step),
    .value (lfsr_value)
  );

  // Scheduler FSM with beat counter, single-entry pending beat and sticky miss flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      beat_cnt_q  <= '0;
      draw_cnt_q  <= '0;
      pending_q   <= 1'b0;
      beat_miss_q <= 1'b0;
    end else if (stop) begin
      state_q    <= StIdle;
      beat_cnt_q <= '0;
      draw_cnt_q <= '0;
      pending_q  <= 1'b0;
    end else if (!pause) begin
      if (state_q != StIdle) begin
        beat_cnt_q <= tick ? '0 : beat_cnt_q + 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StRun;
            beat_cnt_q <= '0;
          end
        end
        StRun: begin
          if (tick || pending_q) begin
            state_q    <= StDraw;
            draw_cnt_q <= '0;
            // A pending beat is consumed now; a coinciding tick becomes the new pending one
            pending_q  <= tick && pending_q;
          end
        end
        StDraw: begin
          draw_cnt_q <= draw_cnt_q + 1'b1;
          if (draw_cnt_q == DrawLast) begin
            state_q <= StPush;
          end
        end
        StPush: begin
          state_q <= StRun;
        end
        default: state_q <= StIdle;
      endcase
      // Beats landing mid-draw are deferred; only one can wait
      if (tick && (state_q != StRun)) begin
        if (pending_q) begin
          beat_miss_q <= 1'b1;
        end else begin
          pending_q <= 1'b1;
        end
      end
    end
  end

  // Queue pointers, occupancy and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (stop) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push && !push_ok) begin
        overflow_q <= 1'b1;
      end
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push_ok && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (!push_ok && pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Queue storage; contents are don't-care while unoccupied
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= lfsr_value[LfsrWidth-1 -: LaneWidth];
    end
  end

  assign note_valid = (count_q != '0);
  assign note_data  = note_valid ? mem_q[rd_ptr_q] : '0;
  assign busy       = (state_q != StIdle);
  assign overflow   = overflow_q;
  assign beat_miss  = beat_miss_q;

endmodule

// File: tb/tb_note_scheduler.sv
// Self-checking bench for note_scheduler with BEAT_TICKS=16, DEPTH=4.
module tb_note_scheduler;

  logic       clk, rst, start, pause, stop, note_ready;
  logic [3:0] note_data;
  logic       note_valid, busy, overflow, beat_miss;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  note_scheduler #(
    .BEAT_TICKS (16),
    .DEPTH      (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pause      (pause),
    .stop       (stop),
    .note_ready (note_ready),
    .note_data  (note_data),
    .note_valid (note_valid),
    .busy       (busy),
    .overflow   (overflow),
    .beat_miss  (beat_miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lane mask of the k-th drawn note since reset: seed advanced 13*(k+1) steps, bits [12:9]
  function automatic logic [3:0] note_of(int k);
    logic [12:0] v;
    v = 13'h1557;
    for (int i = 0; i < 13 * (k + 1); i++) begin
      v = {v[11:0], v[12] ^ v[3] ^ v[2] ^ v[0]};
    end
    return v[12:9];
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic tick_cyc();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) tick_cyc();
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, "_busy"}, 4'(busy), 4'd0);
    chk({name, "_valid"}, 4'(note_valid), 4'd0);
    chk({name, "_data"}, note_data, 4'd0);
    chk({name, "_ovf"}, 4'(overflow), 4'd0);
    chk({name, "_miss"}, 4'(beat_miss), 4'd0);
  endtask

  // Reset, check outputs while held, then leave the bench at cycle 0 ready to drive start
  task automatic do_reset();
    rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0; note_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc = 0;
  endtask

  typedef struct {
    int         cyc;
    logic       busy;
    logic       valid;
    logic [3:0] data;
  } vec_t;

  vec_t vecs[8];

  // Random-phase reference model
  logic [3:0] mq[$];
  int         m_act, m_ndraw;
  logic       m_started, m_ovf;

  task automatic model_step(input logic st, input logic pa, input logic rd);
    logic fullb, popd;
    fullb = (mq.size() == 4);
    popd  = (mq.size() > 0) && rd;
    if (popd) void'(mq.pop_front());
    if (!m_started) begin
      if (st && !pa) begin
        m_started = 1'b1;
        m_act     = 0;
      end
    end else if (!pa) begin
      // Unpaused busy cycles: first PUSH at 29, then every 16
      if (m_act >= 29 && ((m_act - 29) % 16) == 0) begin
        if (fullb && !popd) m_ovf = 1'b1;
        else mq.push_back(note_of(m_ndraw));
        m_ndraw++;
      end
      m_act++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0; note_ready = 1'b0;

    // First note timing and value, consumer always ready
    vecs[0] = '{cyc: 0,  busy: 1'b0, valid: 1'b0, data: 4'd0};
    vecs[1] = '{cyc: 1,  busy: 1'b1, valid: 1'b0, data: 4'd0};
    vecs[2] = '{cyc: 16, busy: 1'b1, valid: 1'b0, data: 4'd0};
    vecs[3] = '{cyc: 30, busy: 1'b1, valid: 1'b0, data: 4'd0};
    vecs[4] = '{cyc: 31, busy: 1'b1, valid: 1'b1, data: note_of(0)};
    vecs[5] = '{cyc: 32, busy: 1'b1, valid: 1'b0, data: 4'd0};
    vecs[6] = '{cyc: 47, busy: 1'b1, valid: 1'b1, data: note_of(1)};
    vecs[7] = '{cyc: 48, busy: 1'b1, valid: 1'b0, data: 4'd0};

    do_reset();
    start = 1'b1;
    note_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      goto(vecs[i].cyc);
      chk($sformatf("first_busy%0d", i), 4'(busy), 4'(vecs[i].busy));
      chk($sformatf("first_valid%0d", i), 4'(note_valid), 4'(vecs[i].valid));
      chk($sformatf("first_data%0d", i), note_data, vecs[i].data);
      if (cyc >= 1) start = 1'b0;
    end

    // Pause for ten cycles delays the first note by ten
    do_reset();
    start = 1'b1; note_ready = 1'b1;
    goto(1);  start = 1'b0;
    goto(10); pause = 1'b1;
    goto(20); pause = 1'b0;
    goto(40); chk("pause_early", 4'(note_valid), 4'd0);
    goto(41); chk("pause_valid", 4'(note_valid), 4'd1);
    chk("pause_data", note_data, note_of(0));

    // Five beats into a stalled consumer: four queued, fifth dropped
    do_reset();
    start = 1'b1;
    goto(1);  start = 1'b0;
    goto(94); chk("fill_valid", 4'(note_valid), 4'd1);
    chk("fill_ovf_before", 4'(overflow), 4'd0);
    goto(95); chk("fill_ovf_after", 4'(overflow), 4'd1);
    note_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_data%0d", i), note_data, note_of(i));
      chk($sformatf("drain_valid%0d", i), 4'(note_valid), 4'd1);
      tick_cyc();
    end
    chk("drain_empty", 4'(note_valid), 4'd0);
    chk("drain_empty_data", note_data, 4'd0);

    // Full queue with a pop in the PUSH cycle: no drop, new note at the tail
    do_reset();
    start = 1'b1;
    goto(1);  start = 1'b0;
    goto(94); chk("fullpop_head", note_data, note_of(0));
    note_ready = 1'b1;
    goto(95); chk("fullpop_ovf", 4'(overflow), 4'd0);
    for (int i = 1; i < 5; i++) begin
      chk($sformatf("fullpop_data%0d", i), note_data, note_of(i));
      tick_cyc();
    end
    chk("fullpop_empty", 4'(note_valid), 4'd0);

    // Stop during PUSH: idle and empty next cycle, LFSR keeps its position
    do_reset();
    start = 1'b1;
    goto(1);  start = 1'b0;
    goto(30); chk("stop_busy_before", 4'(busy), 4'd1);
    stop = 1'b1;
    goto(31); stop = 1'b0;
    chk("stop_busy", 4'(busy), 4'd0);
    chk("stop_valid", 4'(note_valid), 4'd0);
    chk("stop_data", note_data, 4'd0);
    cyc = 0; start = 1'b1;
    goto(1);  start = 1'b0;
    goto(31); chk("stop_resume_valid", 4'(note_valid), 4'd1);
    chk("stop_resume_data", note_data, note_of(1));

    // Reset mid-draw clears outputs at once; restart replays the seed
    do_reset();
    start = 1'b1; note_ready = 1'b1;
    goto(1);  start = 1'b0;
    goto(21); chk("middraw_busy", 4'(busy), 4'd1);
    #1 rst = 1'b1;
    #1 chk_idle_outputs("async_rst");
    do_reset();
    start = 1'b1; note_ready = 1'b1;
    goto(1);  start = 1'b0;
    goto(31); chk("rst_replay_valid", 4'(note_valid), 4'd1);
    chk("rst_replay_data", note_data, note_of(0));

    // Random pause and consumer back-pressure against the reference model
    do_reset();
    mq.delete();
    m_act = 0; m_ndraw = 0; m_started = 1'b0; m_ovf = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 800; i++) begin
      chk("rnd_busy", 4'(busy), 4'(m_started));
      chk("rnd_valid", 4'(note_valid), 4'(mq.size() > 0));
      chk("rnd_data", note_data, (mq.size() > 0) ? mq[0] : 4'd0);
      chk("rnd_ovf", 4'(overflow), 4'(m_ovf));
      if (i > 0) start = 1'b0;
      pause      = (i > 0) && ($urandom_range(0, 5) == 0);
      note_ready = ($urandom_range(0, 3) == 0);
      model_step(start, pause, note_ready);
      tick_cyc();
    end
    chk("rnd_miss", 4'(beat_miss), 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
